// File: rtl/people_scheduler_pkg.sv
// Shared types for the passenger-population engine: slot record, simulator
// state encoding and a floor-modulo helper.
package people_pkg;

  localparam int unsigned ELEV_STATE_W = 4;
  localparam int unsigned FLOOR_W      = 3;
  localparam int unsigned CAR_W        = 2;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'b00,
    SLOT_WAITING = 2'b01,
    SLOT_RIDING  = 2'b10
  } slot_state_t;

  typedef enum logic [1:0] {
    SIM_IDLE  = 2'b00,
    SIM_RUN   = 2'b01,
    SIM_DRAIN = 2'b10,
    SIM_CLEAR = 2'b11
  } sim_state_t;

  typedef struct packed {
    slot_state_t        state;
    logic [FLOOR_W-1:0] src;
    logic [FLOOR_W-1:0] dst;
    logic [CAR_W-1:0]   car;
  } slot_t;

  function automatic logic [FLOOR_W-1:0] floor_mod(input logic [FLOOR_W-1:0] v,
                                                   input int unsigned floors);
    return FLOOR_W'(32'(v) % floors);
  endfunction

endpackage

// File: rtl/people_scheduler_if.sv
// Control/status bundle between the simulation core and people_scheduler.
interface people_scheduler_if #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned FLOORS    = 6,
  parameter int unsigned ELEVATORS = 2,
  parameter int unsigned RAND_W    = 10
);
  logic [1:0]                  sim_state;
  logic [2:0]                  sim_speed;
  logic [WIDTH-1:0]            people_max;
  logic [RAND_W-1:0]           randy;
  logic [4*ELEVATORS-1:0]      elevator_states;
  logic [WIDTH-1:0]            people_generated;
  logic [15:0]                 people_delivered;
  logic [2*FLOORS-1:0]         floors_requested;
  logic [ELEVATORS*FLOORS-1:0] floor_destinations;

  modport master (
    output sim_state, sim_speed, people_max, randy, elevator_states,
    input  people_generated, people_delivered, floors_requested, floor_destinations
  );

  modport slave (
    input  sim_state, sim_speed, people_max, randy, elevator_states,
    output people_generated, people_delivered, floors_requested, floor_destinations
  );
endinterface

// File: rtl/people_scheduler_spawn_timer.sv
// Free-running spawn divider: one-cycle tick every 2**(8-sim_speed) RUN cycles.
module spawn_timer
  import people_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  sim_state_t sim_state_i,
  input  logic [2:0] sim_speed_i,
  output logic       spawn_tick_c_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] thr;

  always_comb begin
    cnt_d          = cnt_q;
    spawn_tick_c_o = 1'b0;
    thr            = 8'hFF >> sim_speed_i;
    case (sim_state_i)
      SIM_CLEAR: cnt_d = '0;
      SIM_RUN: begin
        if (sim_speed_i == 3'd0) begin
          cnt_d = '0;
        end else if (cnt_q == thr) begin
          cnt_d          = '0;
          spawn_tick_c_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/people_scheduler.sv
// Passenger table: spawns riders, boards/alights them against live car states
// and republishes hall calls / cabin destinations once per table sweep.
module people_scheduler
  import people_pkg::*;
#(
  parameter int unsigned PEOPLE    = 63,
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned FLOORS    = 6,
  parameter int unsigned ELEVATORS = 2,
  parameter int unsigned RAND_W    = 10
) (
  input logic               clk,
  input logic               rst,
  people_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = (PEOPLE > 1) ? $clog2(PEOPLE) : 1;
  localparam int unsigned REQ_W = 2 * FLOORS;
  localparam int unsigned DST_W = ELEVATORS * FLOORS;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(PEOPLE - 1);

  sim_state_t sim_state;
  logic       spawn_tick_c;
  logic       unused_randy;

  assign sim_state    = sim_state_t'(bus.sim_state);
  assign unused_randy = ^bus.randy;

  spawn_timer u_spawn_timer (
    .clk            (clk),
    .rst            (rst),
    .sim_state_i    (sim_state),
    .sim_speed_i    (bus.sim_speed),
    .spawn_tick_c_o (spawn_tick_c)
  );

  slot_t              slots_q [PEOPLE];
  slot_t              slots_d [PEOPLE];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   gen_q, gen_d;
  logic [15:0]        deliv_q, deliv_d;
  logic [REQ_W-1:0]   req_sh_q, req_sh_d, req_q, req_d;
  logic [DST_W-1:0]   dst_sh_q, dst_sh_d, dst_q, dst_d;

  logic [WIDTH-1:0]   cap;
  logic               free_found, spawn, board_hit, alight;
  logic [PTR_W-1:0]   free_idx;
  logic [CAR_W-1:0]   board_car;
  slot_t              cur, nxt, sp, post;
  logic [REQ_W-1:0]   req_c;
  logic [DST_W-1:0]   dst_c;
  logic [3:0]         car_door;
  logic [FLOOR_W-1:0] car_floor [4];

  // Unpacked per-car view; unused car entries never open.
  always_comb begin
    car_door = '0;
    for (int e = 0; e < 4; e++) car_floor[e] = '0;
    for (int e = 0; e < int'(ELEVATORS); e++) begin
      car_door[e]  = bus.elevator_states[ELEV_STATE_W*e + 3];
      car_floor[e] = bus.elevator_states[ELEV_STATE_W*e +: FLOOR_W];
    end
  end

  always_comb begin
    slots_d  = slots_q;
    ptr_d    = ptr_q;
    gen_d    = gen_q;
    deliv_d  = deliv_q;
    req_sh_d = req_sh_q;
    dst_sh_d = dst_sh_q;
    req_d    = req_q;
    dst_d    = dst_q;

    cap = (bus.people_max > WIDTH'(PEOPLE)) ? WIDTH'(PEOPLE) : bus.people_max;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(PEOPLE) - 1; i >= 0; i--) begin
      if (slots_q[i].state == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end
    end
    spawn = spawn_tick_c && (sim_state == SIM_RUN) && free_found && (gen_q < cap);

    sp       = '0;
    sp.state = SLOT_WAITING;
    sp.src   = floor_mod(bus.randy[2:0], FLOORS);
    sp.dst   = floor_mod(bus.randy[5:3], FLOORS);
    if (sp.dst == sp.src) sp.dst = floor_mod(sp.src + 3'd1, FLOORS);

    // Scan acts on the pre-edge record; a spawn into the same slot overrides it.
    cur       = slots_q[ptr_q];
    nxt       = cur;
    alight    = 1'b0;
    board_hit = 1'b0;
    board_car = '0;
    for (int e = int'(ELEVATORS) - 1; e >= 0; e--) begin
      if (car_door[e] && car_floor[e] == cur.src) begin
        board_hit = 1'b1;
        board_car = CAR_W'(e);
      end
    end
    if (cur.state == SLOT_WAITING && board_hit) begin
      nxt.state = SLOT_RIDING;
      nxt.car   = board_car;
    end else if (cur.state == SLOT_RIDING && car_door[cur.car] &&
                 car_floor[cur.car] == cur.dst) begin
      nxt.state = SLOT_FREE;
      alight    = 1'b1;
    end
    post = (spawn && free_idx == ptr_q) ? sp : nxt;

    req_c = '0;
    dst_c = '0;
    for (int f = 0; f < int'(FLOORS); f++) begin
      if (post.state == SLOT_WAITING && post.src == FLOOR_W'(f)) begin
        if (post.dst > post.src) req_c[2*f]   = 1'b1;
        else                     req_c[2*f+1] = 1'b1;
      end
      for (int e = 0; e < int'(ELEVATORS); e++) begin
        if (post.state == SLOT_RIDING && post.car == CAR_W'(e) && post.dst == FLOOR_W'(f))
          dst_c[e*int'(FLOORS)+f] = 1'b1;
      end
    end

    case (sim_state)
      SIM_CLEAR: begin
        for (int i = 0; i < int'(PEOPLE); i++) slots_d[i] = '0;
        ptr_d    = '0;
        gen_d    = '0;
        deliv_d  = '0;
        req_sh_d = '0;
        dst_sh_d = '0;
        req_d    = '0;
        dst_d    = '0;
      end
      SIM_RUN, SIM_DRAIN: begin
        slots_d[ptr_q] = nxt;
        if (spawn) slots_d[free_idx] = sp;
        gen_d = gen_q + WIDTH'(spawn) - WIDTH'(alight);
        if (alight && deliv_q != 16'hFFFF) deliv_d = deliv_q + 16'd1;
        if (ptr_q == LAST) begin
          req_d    = req_sh_q | req_c;
          dst_d    = dst_sh_q | dst_c;
          req_sh_d = '0;
          dst_sh_d = '0;
          ptr_d    = '0;
        end else begin
          req_sh_d = req_sh_q | req_c;
          dst_sh_d = dst_sh_q | dst_c;
          ptr_d    = ptr_q + PTR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PEOPLE); i++) slots_q[i] <= '0;
      ptr_q    <= '0;
      gen_q    <= '0;
      deliv_q  <= '0;
      req_sh_q <= '0;
      dst_sh_q <= '0;
      req_q    <= '0;
      dst_q    <= '0;
    end else begin
      slots_q  <= slots_d;
      ptr_q    <= ptr_d;
      gen_q    <= gen_d;
      deliv_q  <= deliv_d;
      req_sh_q <= req_sh_d;
      dst_sh_q <= dst_sh_d;
      req_q    <= req_d;
      dst_q    <= dst_d;
    end
  end

  assign bus.people_generated   = gen_q;
  assign bus.people_delivered   = deliv_q;
  assign bus.floors_requested   = req_q;
  assign bus.floor_destinations = dst_q;

endmodule

// File: tb/tb_people_scheduler.sv
// Scenario bench for people_scheduler: expected values are queued when the
// stimulus is applied and popped when the corresponding output is sampled.
module tb_people_scheduler;

  localparam int unsigned PEOPLE    = 63;
  localparam int unsigned WIDTH     = 6;
  localparam int unsigned FLOORS    = 6;
  localparam int unsigned ELEVATORS = 2;
  localparam int unsigned RAND_W    = 10;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b10;
  localparam logic [1:0] S_CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  people_scheduler_if #(.WIDTH(WIDTH), .FLOORS(FLOORS), .ELEVATORS(ELEVATORS),
                        .RAND_W(RAND_W)) bus ();

  people_scheduler #(.PEOPLE(PEOPLE), .WIDTH(WIDTH), .FLOORS(FLOORS),
                     .ELEVATORS(ELEVATORS), .RAND_W(RAND_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got, exp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] st, input logic [2:0] spd, input logic [5:0] mx,
                       input logic [9:0] r, input logic [7:0] el);
    bus.sim_state       = st;
    bus.sim_speed       = spd;
    bus.people_max      = mx;
    bus.randy           = r;
    bus.elevator_states = el;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(S_IDLE, 3'd0, 6'd0, 10'd0, 8'h00);
    step(); step();
    repeat (4) exp_q.push_back(32'd0);
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reset_gen got=%0h exp=%0h", got, exp); end
    got = 32'(bus.people_delivered); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reset_deliv got=%0h exp=%0h", got, exp); end
    got = 32'(bus.floors_requested); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reset_req got=%0h exp=%0h", got, exp); end
    got = 32'(bus.floor_destinations); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reset_dst got=%0h exp=%0h", got, exp); end
    rst = 1'b0;
  endtask

  // Fill at the fastest rate; expected count from an independent timer model.
  task automatic test_fill();
    int unsigned cnt = 0, mgen = 0, thr;
    thr = (1 << (8 - 7)) - 1;
    drive(S_RUN, 3'd7, 6'd63, 10'd8, 8'h00);
    for (int c = 0; c < 140; c++) begin
      if (cnt == thr) begin
        cnt = 0;
        if (mgen < 63) mgen++;
      end else cnt++;
      exp_q.push_back(32'(mgen));
      step();
      got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL fill_gen cyc=%0d got=%0d exp=%0d", c, got, exp); end
    end
    exp_q.push_back(32'h001);
    exp_q.push_back(32'h000);
    repeat (70) step();
    got = 32'(bus.floors_requested); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL fill_req got=%0h exp=%0h", got, exp); end
    got = 32'(bus.floor_destinations); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL fill_dst got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_cap();
    int unsigned cnt = 0, mgen = 0;
    drive(S_CLEAR, 3'd7, 6'd5, 10'd8, 8'h00);
    exp_q.push_back(32'd0);
    step();
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL cap_clear_gen got=%0d exp=%0d", got, exp); end
    drive(S_RUN, 3'd7, 6'd5, 10'd8, 8'h00);
    for (int c = 0; c < 200; c++) begin
      if (cnt == 1) begin
        cnt = 0;
        if (mgen < 5) mgen++;
      end else cnt++;
      exp_q.push_back(32'(mgen));
      step();
      got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL cap_gen cyc=%0d got=%0d exp=%0d", c, got, exp); end
    end
    exp_q.push_back(32'h001);
    got = 32'(bus.floors_requested); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL cap_req got=%0h exp=%0h", got, exp); end
  endtask

  // randy src=2 dst=2 collides, so the rider is redirected to floor 3 (up call).
  task automatic test_same_floor();
    drive(S_CLEAR, 3'd7, 6'd1, 10'd18, 8'h00);
    step();
    drive(S_RUN, 3'd7, 6'd1, 10'd18, 8'h00);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h010);
    exp_q.push_back(32'h000);
    repeat (130) step();
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL same_gen got=%0d exp=%0d", got, exp); end
    got = 32'(bus.floors_requested); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL same_req got=%0h exp=%0h", got, exp); end
    got = 32'(bus.floor_destinations); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL same_dst got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_board_alight();
    drive(S_RUN, 3'd0, 6'd1, 10'd18, 8'h0A);
    exp_q.push_back(32'h008);
    exp_q.push_back(32'h000);
    exp_q.push_back(32'd1);
    for (int i = 0; i < 140; i++) begin
      if (bus.floor_destinations != '0) break;
      step();
    end
    got = 32'(bus.floor_destinations); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL board_dst got=%0h exp=%0h", got, exp); end
    got = 32'(bus.floors_requested); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL board_req got=%0h exp=%0h", got, exp); end
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL board_gen got=%0d exp=%0d", got, exp); end

    drive(S_RUN, 3'd0, 6'd1, 10'd18, 8'h0B);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    for (int i = 0; i < 70; i++) begin
      if (bus.people_delivered != 16'd0) break;
      step();
    end
    got = 32'(bus.people_delivered); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL alight_deliv got=%0d exp=%0d", got, exp); end
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL alight_gen got=%0d exp=%0d", got, exp); end

    exp_q.push_back(32'h000);
    for (int i = 0; i < 140; i++) begin
      if (bus.floor_destinations == '0) break;
      step();
    end
    got = 32'(bus.floor_destinations); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL alight_dst got=%0h exp=%0h", got, exp); end
  endtask

  task automatic test_drain();
    drive(S_CLEAR, 3'd7, 6'd20, 10'd8, 8'h00);
    exp_q.push_back(32'd0);
    step();
    got = 32'(bus.people_delivered); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL drain_clear_deliv got=%0d exp=%0d", got, exp); end
    drive(S_RUN, 3'd7, 6'd20, 10'd8, 8'h00);
    exp_q.push_back(32'd20);
    repeat (60) step();
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL drain_fill_gen got=%0d exp=%0d", got, exp); end

    drive(S_DRAIN, 3'd7, 6'd20, 10'd8, 8'h08);
    for (int c = 0; c < 130; c++) begin
      exp_q.push_back(32'd20);
      step();
      got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL drain_hold_gen cyc=%0d got=%0d exp=%0d", c, got, exp); end
    end
    exp_q.push_back(32'h002);
    exp_q.push_back(32'h000);
    got = 32'(bus.floor_destinations); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL drain_dst got=%0h exp=%0h", got, exp); end
    got = 32'(bus.floors_requested); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL drain_req got=%0h exp=%0h", got, exp); end

    drive(S_DRAIN, 3'd7, 6'd20, 10'd8, 8'h09);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd20);
    repeat (70) step();
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL drain_empty_gen got=%0d exp=%0d", got, exp); end
    got = 32'(bus.people_delivered); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL drain_deliv got=%0d exp=%0d", got, exp); end
  endtask

  task automatic test_clear();
    drive(S_RUN, 3'd7, 6'd63, 10'd8, 8'h00);
    exp_q.push_back(32'd40);
    for (int i = 0; i < 100; i++) begin
      if (bus.people_generated == 6'd40) break;
      step();
    end
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL clear_pre_gen got=%0d exp=%0d", got, exp); end

    drive(S_CLEAR, 3'd7, 6'd63, 10'd8, 8'h00);
    repeat (4) exp_q.push_back(32'd0);
    step();
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL clear_gen got=%0d exp=%0d", got, exp); end
    got = 32'(bus.people_delivered); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL clear_deliv got=%0d exp=%0d", got, exp); end
    got = 32'(bus.floors_requested); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL clear_req got=%0h exp=%0h", got, exp); end
    got = 32'(bus.floor_destinations); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL clear_dst got=%0h exp=%0h", got, exp); end

    // New riders: src=4, dst=1 -> down call at floor 4 (bit 9).
    drive(S_RUN, 3'd7, 6'd63, 10'd12, 8'h00);
    exp_q.push_back(32'd1);
    step(); step();
    got = 32'(bus.people_generated); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL resume_gen got=%0d exp=%0d", got, exp); end
    exp_q.push_back(32'h000);
    repeat (61) step();
    got = 32'(bus.floors_requested); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL resume_sweep1_req got=%0h exp=%0h", got, exp); end
    exp_q.push_back(32'h200);
    repeat (63) step();
    got = 32'(bus.floors_requested); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL resume_sweep2_req got=%0h exp=%0h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_cap();
    test_same_floor();
    test_board_alight();
    test_drain();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
